// File: rtl/trig_seq_detect.sv
// rtl/trig_seq_detect.sv - plaintext sequence detector that fires a registered Tj_Trig pulse
module trig_seq_detect #(
    parameter int              DATA_W    = 128,
    parameter int              SEQ_LEN   = 4,
    parameter logic [DATA_W-1:0] PAT0    = 128'h3243f6a8885a308d313198a2e0370734,
    parameter logic [DATA_W-1:0] PAT1    = PAT0 + 1,
    parameter logic [DATA_W-1:0] PAT2    = PAT0 + 2,
    parameter logic [DATA_W-1:0] PAT3    = PAT0 + 3,
    parameter int              PULSE_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] state,
    input  logic              load,
    output logic              Tj_Trig,
    output logic [2:0]        seq_idx,
    output logic [7:0]        fired_cnt
);

    localparam int CW = (PULSE_LEN < 2) ? 1 : $clog2(PULSE_LEN + 1);
    localparam logic [2:0]    SEQ_LAST = 3'(SEQ_LEN - 1);
    localparam logic [CW-1:0] PULSE_L  = CW'(PULSE_LEN);

    typedef enum logic {S_MATCH, S_FIRE} fsm_t;

    fsm_t              fsm_q;
    logic [2:0]        idx_q;
    logic [CW-1:0]     pcnt_q;
    logic              trig_q;
    logic [7:0]        fired_q;
    logic [DATA_W-1:0] exp_pat;
    logic              hit;
    logic              hit0;

    always_comb begin
        exp_pat = PAT3;
        case (idx_q)
            3'd0:    exp_pat = PAT0;
            3'd1:    exp_pat = PAT1;
            3'd2:    exp_pat = PAT2;
            default: exp_pat = PAT3;
        endcase
    end

    assign hit  = (state == exp_pat);
    assign hit0 = (state == PAT0);

    // Unknown plaintext bits make the compares X, which the if-conditions treat as mismatch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= S_MATCH;
            idx_q   <= 3'd0;
            pcnt_q  <= '0;
            trig_q  <= 1'b0;
            fired_q <= 8'd0;
        end else begin
            case (fsm_q)
                S_MATCH: begin
                    if (load && hit) begin
                        if (idx_q == SEQ_LAST) begin
                            fsm_q  <= S_FIRE;
                            idx_q  <= 3'd0;
                            pcnt_q <= CW'(1);
                            trig_q <= 1'b1;
                            if (fired_q != 8'hFF)
                                fired_q <= fired_q + 8'd1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else if (load) begin
                        if (hit0)
                            idx_q <= 3'd1;
                        else
                            idx_q <= 3'd0;
                    end
                end
                default: begin
                    // Loads arriving while the pulse is high are dropped entirely.
                    if (pcnt_q == PULSE_L) begin
                        fsm_q  <= S_MATCH;
                        trig_q <= 1'b0;
                        pcnt_q <= '0;
                    end else begin
                        pcnt_q <= pcnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign Tj_Trig   = trig_q;
    assign seq_idx   = idx_q;
    assign fired_cnt = fired_q;

endmodule
